// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an S-box RAM port (KSA_INIT_EN compiles in the identity fill)
module ksa_engine #(
  parameter int WIDTH     = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH*KEY_BYTES-1:0] secret_key,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           mem_addr,
  output logic [WIDTH-1:0]           mem_wdata,
  output logic                       mem_wren,
  input  logic [WIDTH-1:0]           mem_rdata
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};
  typedef enum logic [3:0] {
    IDLE,
`ifdef KSA_INIT_EN
    INIT,
`endif
    READ_I, CAP_I, READ_J, CAP_J, WRITE_I, WRITE_J, DONE
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0] kb_q, kb_d;
  logic [WIDTH*KEY_BYTES-1:0] key_q, key_d;
  logic [WIDTH-1:0] kbyte [2**KW];
  for (genvar g = 0; g < 2**KW; g++) begin : g_kb
    if (g < KEY_BYTES) begin : g_use
      assign kbyte[g] = key_q[(KEY_BYTES-1-g)*WIDTH +: WIDTH];
    end else begin : g_pad
      assign kbyte[g] = '0;
    end
  end
  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = state_q == DONE;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      kb_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      si_q <= si_d;
      sj_q <= sj_d;
      kb_q <= kb_d;
      key_q <= key_d;
    end
  end
  // next-state, datapath updates and RAM port drive
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    si_d = si_q;
    sj_d = sj_q;
    kb_d = kb_q;
    key_d = key_q;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wren = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        key_d = secret_key;
        i_d = '0;
        j_d = '0;
        kb_d = '0;
`ifdef KSA_INIT_EN
        state_d = INIT;
`else
        state_d = READ_I;
`endif
      end
`ifdef KSA_INIT_EN
      INIT: begin
        mem_addr = i_q;
        mem_wdata = i_q;
        mem_wren = 1'b1;
        i_d = i_q + WIDTH'(1);
        state_d = (i_q == LAST) ? READ_I : INIT;
      end
`endif
      READ_I: begin
        mem_addr = i_q;
        state_d = CAP_I;
      end
      CAP_I: begin
        si_d = mem_rdata;
        j_d = j_q + mem_rdata + kbyte[kb_q];
        state_d = READ_J;
      end
      READ_J: begin
        mem_addr = j_q;
        state_d = CAP_J;
      end
      CAP_J: begin
        sj_d = mem_rdata;
        state_d = WRITE_I;
      end
      WRITE_I: begin
        mem_addr = i_q;
        mem_wdata = sj_q;
        mem_wren = 1'b1;
        state_d = WRITE_J;
      end
      WRITE_J: begin
        mem_addr = j_q;
        mem_wdata = si_q;
        mem_wren = 1'b1;
        state_d = (i_q == LAST) ? DONE : READ_I;
        i_d = (i_q == LAST) ? i_q : i_q + WIDTH'(1);
        kb_d = (i_q == LAST) ? kb_q : (kb_q == KW'(KEY_BYTES-1)) ? '0 : kb_q + KW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: scoreboard bench for ksa_engine at 8-bit/3-byte and 4-bit/1-byte configurations
module tb_ksa_engine;
`ifdef KSA_INIT_EN
  localparam int INIT = 1;
`else
  localparam int INIT = 0;
`endif
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1;
  logic start8 = 0, start4 = 0, fill8 = 0, fill4 = 0;
  logic [23:0] key8 = 0;
  logic [3:0] key4 = 0;
  logic busy8, done8, wren8, busy4, done4, wren4;
  logic [7:0] addr8, wdata8, rdata8;
  logic [3:0] addr4, wdata4, rdata4;
  logic [7:0] ram8 [256];
  logic [3:0] ram4 [16];
  int total = 0, bad = 0;
  int exp8 [256], exp4 [16], m [256];
  logic [2047:0] qs8 [$];
  logic [63:0] qs4 [$];
  int ql8 [$], ql4 [$];
  int cnt8 = 0, cnt4 = 0;
  logic busy8_p = 0, done8_p = 0, busy4_p = 0, done4_p = 0;

  ksa_engine #(.WIDTH(8), .KEY_BYTES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .secret_key(key8), .busy(busy8), .done(done8),
    .mem_addr(addr8), .mem_wdata(wdata8), .mem_wren(wren8), .mem_rdata(rdata8));
  ksa_engine #(.WIDTH(4), .KEY_BYTES(1)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .secret_key(key4), .busy(busy4), .done(done4),
    .mem_addr(addr4), .mem_wdata(wdata4), .mem_wren(wren4), .mem_rdata(rdata4));

  always @(posedge clk) begin
    if (fill8) for (int k = 0; k < 256; k++) ram8[k] <= INIT ? 8'(~k) : 8'(k);
    else if (wren8) ram8[addr8] <= wdata8;
    rdata8 <= ram8[addr8];
  end
  always @(posedge clk) begin
    if (fill4) for (int k = 0; k < 16; k++) ram4[k] <= INIT ? 4'(~k) : 4'(k);
    else if (wren4) ram4[addr4] <= wdata4;
    rdata4 <= ram4[addr4];
  end

  function automatic void chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endfunction

  // textbook RC4 key schedule on m[0..n-1]; key byte 0 is the most significant
  function automatic void ksa(input int n, input logic [127:0] key, input int kb, input int w);
    int j = 0, t;
    for (int i = 0; i < n; i++) begin
      j = (j + m[i] + int'((key >> (w * (kb - 1 - (i % kb)))) & 128'(n - 1))) % n;
      t = m[i]; m[i] = m[j]; m[j] = t;
    end
  endfunction

  task automatic issue8(input logic [23:0] k, input bit refill);
    logic [2047:0] ps;
    if (refill) begin
      fill8 = 1; @(posedge clk); #1 fill8 = 0;
    end
    if (refill || INIT) for (int x = 0; x < 256; x++) exp8[x] = x;
    for (int x = 0; x < 256; x++) m[x] = exp8[x];
    ksa(256, 128'(k), 3, 8);
    for (int x = 0; x < 256; x++) begin exp8[x] = m[x]; ps[8*x +: 8] = 8'(m[x]); end
    qs8.push_back(ps);
    ql8.push_back(1536 + INIT * 256);
    key8 = k; start8 = 1; @(posedge clk); #1 start8 = 0;
  endtask

  task automatic issue4(input logic [3:0] k, input bit refill);
    logic [63:0] ps;
    if (refill) begin
      fill4 = 1; @(posedge clk); #1 fill4 = 0;
    end
    if (refill || INIT) for (int x = 0; x < 16; x++) exp4[x] = x;
    for (int x = 0; x < 16; x++) m[x] = exp4[x];
    ksa(16, 128'(k), 1, 4);
    for (int x = 0; x < 16; x++) begin exp4[x] = m[x]; ps[4*x +: 4] = 4'(m[x]); end
    qs4.push_back(ps);
    ql4.push_back(96 + INIT * 16);
    key4 = k; start4 = 1; @(posedge clk); #1 start4 = 0;
  endtask

  task automatic wait8(input int poke_at, input int reset_at);
    int c = 0;
    bit aborted = 0;
    while (!done8 && c < 3000) begin
      @(posedge clk); #1;
      c++;
      start8 = 0;
      if (c == poke_at) begin key8 = ~key8; start8 = 1; end
      if (c == reset_at) begin
        reset = 1; @(posedge clk); #1;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_wren", int'(wren8), 0);
        reset = 0;
        void'(qs8.pop_back());
        void'(ql8.pop_back());
        aborted = 1;
        break;
      end
    end
    start8 = 0;
    if (!aborted) chk("done8_seen", int'(done8), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait4();
    int c = 0;
    while (!done4 && c < 300) begin @(posedge clk); #1; c++; end
    chk("done4_seen", int'(done4), 1);
    @(negedge clk); #1;
  endtask

  // monitor for the 8-bit engine: idle writes, init sequence, latency and final S-box
  always @(negedge clk) begin
    logic [2047:0] ps;
    bit seen [256];
    int mism, uniq, lat;
    chk("wren8_idle", int'(wren8 && !busy8), 0);
    if (busy8) begin
      if (!busy8_p) cnt8 = 0;
      if (INIT && cnt8 < 256) chk("init8_wr", int'({wren8, addr8, wdata8}), int'({1'b1, 8'(cnt8), 8'(cnt8)}));
      if (cnt8 == INIT * 256) chk("first_rd8", int'({wren8, addr8}), 0);
      cnt8++;
    end
    if (done8 && !done8_p) begin
      if (qs8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        ps = qs8.pop_front();
        lat = ql8.pop_front();
        chk("lat8", cnt8, lat);
        mism = 0; uniq = 0;
        for (int k = 0; k < 256; k++) seen[k] = 0;
        for (int k = 0; k < 256; k++) begin
          if (ram8[k] !== ps[8*k +: 8]) mism++;
          if (!seen[ram8[k]]) uniq++;
          seen[ram8[k]] = 1;
        end
        chk("sbox8", mism, 0);
        chk("perm8", uniq, 256);
      end
    end
    busy8_p = busy8;
    done8_p = done8;
  end

  // monitor for the 4-bit engine
  always @(negedge clk) begin
    logic [63:0] ps;
    bit seen [16];
    int mism, uniq, lat;
    chk("wren4_idle", int'(wren4 && !busy4), 0);
    if (busy4) begin
      if (!busy4_p) cnt4 = 0;
      if (INIT && cnt4 < 16) chk("init4_wr", int'({wren4, addr4, wdata4}), int'({1'b1, 4'(cnt4), 4'(cnt4)}));
      if (cnt4 == INIT * 16) chk("first_rd4", int'({wren4, addr4}), 0);
      cnt4++;
    end
    if (done4 && !done4_p) begin
      if (qs4.size() == 0) chk("unexpected_done4", 1, 0);
      else begin
        ps = qs4.pop_front();
        lat = ql4.pop_front();
        chk("lat4", cnt4, lat);
        mism = 0; uniq = 0;
        for (int k = 0; k < 16; k++) seen[k] = 0;
        for (int k = 0; k < 16; k++) begin
          if (ram4[k] !== ps[4*k +: 4]) mism++;
          if (!seen[ram4[k]]) uniq++;
          seen[ram4[k]] = 1;
        end
        chk("sbox4", mism, 0);
        chk("perm4", uniq, 16);
      end
    end
    busy4_p = busy4;
    done4_p = done4;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_wren8", int'(wren8), 0);
    chk("rst_addr8", int'(addr8), 0);
    chk("rst_wdata8", int'(wdata8), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    repeat (100) @(posedge clk);
    #1;
    issue8(24'h000249, 1); wait8(0, 0);
    issue8(24'($urandom), 1); wait8(500, 0);
    issue8(24'($urandom), 1); wait8(0, 900);
    issue8(24'h123456, 1); wait8(0, 0);
    issue8(24'($urandom), 0); wait8(0, 0);
    issue8(24'($urandom), 1); wait8(0, 0);
    issue4(4'hA, 1); wait4();
    issue4(4'hA, 0); wait4();
    repeat (3) begin issue4(4'($urandom), 0); wait4(); end
    chk("q8_empty", qs8.size(), 0);
    chk("q4_empty", qs4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ksa_engine.md
Name: ksa_engine

Overview:
- Parametrised RC4 key-scheduling engine. It owns the S-box RAM port and runs the optional identity fill, then the swap loop, for a key of KEY_BYTES bytes.
- It is instantiated under the board top level. The board top level supplies clk and reset, drives start and secret_key, and monitors busy and done.
- It generalises the fixed 8-bit, 3-byte, 256-entry key-schedule block. Width, key length and init mode are selectable.
- It adds a start/busy/done handshake and defined restart and reset behaviour.

Parameters:
- WIDTH, 8, S-box entry width and index width. Depth is 2**WIDTH. All index and sum arithmetic is modulo 2**WIDTH.
- KEY_BYTES, 3, number of WIDTH-bit key bytes in secret_key. Legal range is 1..16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE or DONE.
- secret_key  input  WIDTH*KEY_BYTES  key; key byte 0 is the most significant WIDTH bits.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- mem_addr  output  WIDTH  S-box RAM address.
- mem_wdata  output  WIDTH  S-box RAM write data.
- mem_wren  output  1  S-box RAM write enable.
- mem_rdata  input  WIDTH  S-box RAM read data; valid the cycle after mem_addr is presented with mem_wren=0.

Behaviour:
- Reset is synchronous and active-high. Reset values: busy=0, done=0, mem_wren=0, mem_addr=0, mem_wdata=0, i=0, j=0, state IDLE.
- Reset asserted mid-run aborts immediately; RAM contents are then undefined.
- Accepting start:
  - start is accepted in IDLE or DONE.
  - On acceptance, secret_key is latched into key_reg, i=0, j=0, done clears and busy rises on the next cycle.
  - start while busy is ignored. Later changes to secret_key do not affect the run in progress.
- State sequence: IDLE -> [INIT] -> READ_I -> CAP_I -> READ_J -> CAP_J -> WRITE_I -> WRITE_J -> (READ_I | DONE).
- INIT (only when KSA_INIT_EN is defined):
  - One write per cycle: mem_addr=i, mem_wdata=i, mem_wren=1, i++.
  - Runs for 2**WIDTH cycles. Leaves with i wrapped to 0 and goes to READ_I.
- READ_I: mem_addr=i, mem_wren=0.
- CAP_I:
  - si <= mem_rdata.
  - j <= j + mem_rdata + key_reg byte (i mod KEY_BYTES), truncated to WIDTH bits.
  - The byte selector is a counter that wraps at KEY_BYTES-1; no divider.
- READ_J: mem_addr=j, mem_wren=0.
- CAP_J: sj <= mem_rdata.
- WRITE_I: mem_addr=i, mem_wdata=sj, mem_wren=1.
- WRITE_J:
  - mem_addr=j, mem_wdata=si, mem_wren=1.
  - If i == 2**WIDTH-1, go to DONE; otherwise i++ and go to READ_I.
- i == j: both writes store the same value, which is the correct no-op swap. No special case.
- Each iteration takes exactly 6 cycles. The swap loop takes 6*2**WIDTH cycles.
- mem_wren is high only in INIT, WRITE_I and WRITE_J. mem_wren is never high in IDLE or DONE.
- DONE: busy=0, done=1, mem_wren=0. Holds until an accepted start or reset.
- Latency from the first busy cycle to the done rising edge:
  - With KSA_INIT_EN: 2**WIDTH + 6*2**WIDTH cycles, i.e. 1792 at WIDTH=8.
  - Without KSA_INIT_EN: 6*2**WIDTH cycles, i.e. 1536 at WIDTH=8.
  - busy falls in the same cycle done rises.
- All key bytes, i and j are WIDTH-bit and wrap silently.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined: the INIT phase is compiled in and every run starts by writing S[k]=k for all k.
- Undefined: the INIT state is removed and a run goes straight to READ_I. The RAM must already hold the identity permutation, via an external fill or a .mif file.

Test Plan:
1. Reset check: assert reset for 2 cycles, then release -> busy=0, done=0, mem_wren=0, mem_addr=0. Hold start=0 for 100 cycles -> no RAM writes.
2. Init pass: KSA_INIT_EN defined, WIDTH=8, pulse start -> 256 consecutive writes with addr=data=0..255, then the first READ_I at addr 0.
3. Full run: WIDTH=8, KEY_BYTES=3, secret_key=24'h000249, behavioural RAM model with 1-cycle read latency.
   - Final RAM equals the software RC4 KSA output for that key.
   - done rises 1792 cycles after busy rises.
   - Every entry 0..255 appears exactly once.
4. Start while busy: start pulsed at cycle 500 of a run, with secret_key changed -> no effect. Final S still matches the originally latched key; cycle count unchanged.
5. Reset mid-run: reset at cycle 900 -> next cycle busy=0, done=0, mem_wren=0.
   - A new start with key 24'h123456 completes correctly against the model.
6. Parametrisation:
   - WIDTH=4, KEY_BYTES=1, KSA_INIT_EN undefined, RAM preloaded with the identity, key=4'hA -> result matches the model; done after 96 cycles.
   - Restart from DONE with the same key -> second run starts from the scrambled S and matches the model applied twice.
